// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the
// write-back stage and register file.
package wb_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_mux.sv
// Write-back source selector:
// load data or ALU result.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  logic              memToReg,
  input  logic [DATA_W-1:0] aluRes,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] wbData
);
  assign wbData = memToReg ? memData : aluRes;
endmodule

// File: rtl/wb_regfile.sv
// 31x32 register file with same-cycle
// write-back bypass and retire counter.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  RegWrite_i,
  input  logic                  MemToReg_i,
  input  logic [DATA_W-1:0]     MemAddr_i,
  input  logic [DATA_W-1:0]     MemRead_Data_i,
  input  logic [REG_ADDR_W-1:0] Rd_Addr_i,
  input  logic [REG_ADDR_W-1:0] RS1addr_i,
  input  logic [REG_ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0]     RS1data_o,
  output logic [DATA_W-1:0]     RS2data_o,
  output logic [DATA_W-1:0]     WB_Data_o,
  output logic [DATA_W-1:0]     Retired_o
);
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] retired;
  logic [DATA_W-1:0] wbData;
  logic              commit;

  wb_mux uMux (
    .memToReg (MemToReg_i),
    .aluRes   (MemAddr_i),
    .memData  (MemRead_Data_i),
    .wbData   (wbData)
  );

  // rst_i also gates the bypass path
  assign commit = start_i & RegWrite_i & ~rst_i
                & (Rd_Addr_i != ZERO_REG);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= '0;
      retired <= '0;
    end else if (commit) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (Rd_Addr_i == REG_ADDR_W'(i))
          regs[i] <= wbData;
      retired <= retired + 1'b1;
    end
  end

  always_comb begin
    RS1data_o = '0;
    RS2data_o = '0;
    if (RS1addr_i != ZERO_REG)
      RS1data_o = regs[RS1addr_i];
    if (RS2addr_i != ZERO_REG)
      RS2data_o = regs[RS2addr_i];
    if (commit && RS1addr_i == Rd_Addr_i)
      RS1data_o = wbData;
    if (commit && RS2addr_i == Rd_Addr_i)
      RS2data_o = wbData;
  end

  assign WB_Data_o = wbData;
  assign Retired_o = retired;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: model
// pushes expectations, DUT outputs pop them.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        regWrite = 1'b0;
  logic        memToReg = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] memData = '0;
  logic [4:0]  rdAddr = '0;
  logic [4:0]  rs1Addr = '0;
  logic [4:0]  rs2Addr = '0;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] wbData;
  logic [31:0] retired;

  logic [31:0] expQ [$];
  logic [31:0] modelRegs [32];
  logic [31:0] modelRet;
  int nCmp = 0;
  int nErr = 0;

  wb_regfile dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .RegWrite_i     (regWrite),
    .MemToReg_i     (memToReg),
    .MemAddr_i      (memAddr),
    .MemRead_Data_i (memData),
    .Rd_Addr_i      (rdAddr),
    .RS1addr_i      (rs1Addr),
    .RS2addr_i      (rs2Addr),
    .RS1data_o      (rs1Data),
    .RS2data_o      (rs2Data),
    .WB_Data_o      (wbData),
    .Retired_o      (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mWb();
    return memToReg ? memData : memAddr;
  endfunction

  function automatic logic mCommit();
    return start && regWrite && !rst && rdAddr != 5'd0;
  endfunction

  task automatic setIn(input logic st, input logic rw,
                       input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
    start = st; regWrite = rw; memToReg = m2r;
    memAddr = alu; memData = mem; rdAddr = rd;
    rs1Addr = r1; rs2Addr = r2;
  endtask

  task automatic modelEdge();
    if (mCommit()) begin
      modelRegs[rdAddr] = mWb();
      modelRet = modelRet + 1;
    end
  endtask

  task automatic modelReset();
    foreach (modelRegs[i]) modelRegs[i] = '0;
    modelRet = '0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    modelReset();
    #7;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      setIn(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      expQ.push_back(modelRegs[a]);
      expQ.push_back(modelRegs[31 - a]);
      #1;
      e = expQ.pop_front(); nCmp++;
      if (rs1Data !== e) begin
        nErr++;
        $display("FAIL reset_rs1 a=%0d got %h want %h", a, rs1Data, e);
      end
      e = expQ.pop_front(); nCmp++;
      if (rs2Data !== e) begin
        nErr++;
        $display("FAIL reset_rs2 a=%0d got %h want %h", a, rs2Data, e);
      end
    end
    nCmp++;
    if (retired !== 32'd0) begin
      nErr++;
      $display("FAIL reset_ret got %h want 0", retired);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    @(negedge clk);
    setIn(1, 1, 0, 32'h1234ABCD, 32'h0BAD0BAD, 5, 5, 0);
    expQ.push_back(32'h1234ABCD);
    #1;
    e = expQ.pop_front(); nCmp++;
    if (rs1Data !== e) begin
      nErr++;
      $display("FAIL bypass_pre got %h want %h", rs1Data, e);
    end
    expQ.push_back(32'h1234ABCD);
    @(posedge clk); modelEdge();
    #1;
    setIn(0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    e = expQ.pop_front(); nCmp++;
    if (rs1Data !== e) begin
      nErr++;
      $display("FAIL bypass_post got %h want %h", rs1Data, e);
    end
    nCmp++;
    if (retired !== modelRet) begin
      nErr++;
      $display("FAIL bypass_ret got %h want %h", retired, modelRet);
    end
  endtask

  task automatic test_x0();
    logic [31:0] e;
    @(negedge clk);
    setIn(1, 1, 1, 32'h0, 32'hFFFFFFFF, 0, 0, 0);
    expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nCmp++;
    if (rs1Data !== e) begin
      nErr++;
      $display("FAIL x0_pre got %h want %h", rs1Data, e);
    end
    nCmp++;
    if (wbData !== 32'hFFFFFFFF) begin
      nErr++;
      $display("FAIL x0_wbdata got %h want ffffffff", wbData);
    end
    @(posedge clk); modelEdge();
    #1;
    nCmp++;
    if (rs2Data !== 32'h0 || retired !== modelRet) begin
      nErr++;
      $display("FAIL x0_post got %h/%h want 0/%h", rs2Data, retired, modelRet);
    end
  endtask

  task automatic test_start();
    @(negedge clk);
    setIn(0, 1, 1, 32'h0, 32'hCAFEF00D, 7, 7, 7);
    #1;
    nCmp++;
    if (rs1Data !== 32'h0 || rs2Data !== 32'h0) begin
      nErr++;
      $display("FAIL nostart_bypass got %h/%h want 0", rs1Data, rs2Data);
    end
    @(posedge clk); modelEdge();
    #1;
    nCmp++;
    if (rs1Data !== modelRegs[7] || retired !== modelRet) begin
      nErr++;
      $display("FAIL nostart_write got %h/%h want %h/%h",
               rs1Data, retired, modelRegs[7], modelRet);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); modelEdge();
    #1;
    start = 1'b0;
    #1;
    nCmp++;
    if (rs1Data !== 32'hCAFEF00D || modelRegs[7] !== 32'hCAFEF00D) begin
      nErr++;
      $display("FAIL start_write got %h want cafef00d", rs1Data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [4:0] rd;
    logic [4:0] r2;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rd = 5'($urandom_range(0, 31));
      r2 = (k % 2 == 0) ? rd : 5'($urandom_range(0, 31));
      setIn(1, 1'($urandom_range(0, 3) != 0), 1'(k % 3 == 0),
            $urandom, $urandom, rd, rd, r2);
      expQ.push_back(mCommit() ? mWb() : modelRegs[rd]);
      expQ.push_back(mCommit() && r2 == rd ? mWb() : modelRegs[r2]);
      #1;
      e = expQ.pop_front(); nCmp++;
      if (rs1Data !== e) begin
        nErr++;
        $display("FAIL b2b_rs1 k=%0d got %h want %h", k, rs1Data, e);
      end
      e = expQ.pop_front(); nCmp++;
      if (rs2Data !== e) begin
        nErr++;
        $display("FAIL b2b_rs2 k=%0d got %h want %h", k, rs2Data, e);
      end
      @(posedge clk); modelEdge();
      #1;
      nCmp++;
      if (retired !== modelRet) begin
        nErr++;
        $display("FAIL b2b_ret k=%0d got %h want %h", k, retired, modelRet);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    force dut.retired = 32'hFFFFFFFF;
    #1;
    release dut.retired;
    modelRet = 32'hFFFFFFFF;
    #1;
    nCmp++;
    if (retired !== modelRet) begin
      nErr++;
      $display("FAIL wrap_preload got %h want %h", retired, modelRet);
    end
    setIn(1, 1, 0, 32'h55, 0, 9, 9, 0);
    @(posedge clk); modelEdge();
    #1;
    start = 1'b0;
    nCmp++;
    if (retired !== 32'h0 || modelRet !== 32'h0) begin
      nErr++;
      $display("FAIL wrap got %h want 00000000", retired);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    setIn(1, 1, 0, 32'hA5A5A5A5, 0, 3, 3, 3);
    @(posedge clk); modelEdge();
    #1;
    nCmp++;
    if (rs1Data !== 32'hA5A5A5A5) begin
      nErr++;
      $display("FAIL ar_setup got %h want a5a5a5a5", rs1Data);
    end
    memAddr = 32'h11111111;
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    nCmp++;
    if (rs1Data !== 32'h0 || rs2Data !== 32'h0 || retired !== 32'h0) begin
      nErr++;
      $display("FAIL ar_immediate got %h/%h/%h want 0",
               rs1Data, rs2Data, retired);
    end
    @(posedge clk);
    #1;
    nCmp++;
    if (rs1Data !== 32'h0 || retired !== 32'h0) begin
      nErr++;
      $display("FAIL ar_edge got %h/%h want 0", rs1Data, retired);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    nCmp++;
    if (rs1Data !== modelRegs[3] || retired !== modelRet) begin
      nErr++;
      $display("FAIL ar_release got %h/%h want 0", rs1Data, retired);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_start();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
